frame_rx: RTL and testbench

Byte-level frame receiver that sits directly upstream of the checksum stage on the bus node's receive path.
- Consumes bytes from the serial line receiver as a one-cycle strobe per byte.
- Frames bytes as START, ADDR, DATA, CRC and presents the DATA/CRC pair to a checksum instance.
- Delivers accepted payloads with a one-cycle valid pulse; rejected frames raise an error pulse and increment a saturating counter.

---
 rtl/bus_pkg.sv | 29 ++
 rtl/frame_rx_checksum.sv | 20 ++
 rtl/frame_rx.sv | 161 ++++++++++++++++
 tb/tb_frame_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared frame-receive state encoding, delimiter/address/key
//               constants and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t ADDR  = 3'd1;
    localparam state_t DATA  = 3'd2;
    localparam state_t CRC   = 3'd3;
    localparam state_t CHECK = 3'd4;

    localparam logic [7:0] START_BYTE  = 8'h7E;
    localparam logic [7:0] BCAST_ADDR  = 8'hFF;
    localparam logic [7:0] DEFAULT_KEY = 8'h37;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_rx_checksum.sv
// ============================================================================
// Module      : frame_rx_checksum
// Description : Keyed checksum check; ok is high when crc == data ^ KEY.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_rx_checksum #(
    parameter logic [7:0] KEY = 8'h37
) (
    input  logic [7:0] data,
    input  logic [7:0] crc,
    output logic       ok
);

    assign ok = (crc == (data ^ KEY));

endmodule

`default_nettype wire

// File: rtl/frame_rx.sv
// ============================================================================
// Module      : frame_rx
// Description : START/ADDR/DATA/CRC byte-frame receiver feeding a checksum
//               check. Optional inter-byte timeout: FRAME_RX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_rx
    import bus_pkg::*;
#(
    parameter logic [7:0] KEY       = DEFAULT_KEY,
    parameter logic [7:0] START     = START_BYTE,
    parameter logic [7:0] NODE_ADDR = 8'h01,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] frame_data,
    output logic       frame_valid,
    output logic       crc_err,
    output logic       timeout_err,
    output logic [7:0] err_count
);

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] frame_data_q, frame_data_d;
    logic       frame_valid_q, frame_valid_d;
    logic       crc_err_q, crc_err_d;
    logic [7:0] err_count_q, err_count_d;
    logic       timeout_hit;
    logic       sum_ok;

    frame_rx_checksum #(
        .KEY (KEY)
    ) u_checksum (
        .data (data_q),
        .crc  (crc_q),
        .ok   (sum_ok)
    );

`ifdef FRAME_RX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q;
    logic             in_frame;

    assign in_frame    = (state_q == ADDR) || (state_q == DATA) || (state_q == CRC);
    // A strobe in the expiry cycle wins and is processed as a normal byte.
    assign timeout_hit = in_frame && !rx_valid && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (in_frame && !rx_valid && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_hit;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        crc_d         = crc_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        crc_err_d     = 1'b0;
        err_count_d   = err_count_q;

        if (timeout_hit) begin
            state_d     = IDLE;
            err_count_d = sat_inc(err_count_q);
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid && (rx_byte == START)) begin
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        state_d = ((rx_byte == NODE_ADDR) || (rx_byte == BCAST_ADDR)) ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        data_d  = rx_byte;
                        state_d = CRC;
                    end
                end
                CRC: begin
                    if (rx_valid) begin
                        crc_d   = rx_byte;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    // Any strobe landing here is deliberately dropped.
                    if (sum_ok) begin
                        frame_data_d  = data_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        crc_err_d   = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            data_q        <= 8'h00;
            crc_q         <= 8'h00;
            frame_data_q  <= 8'h00;
            frame_valid_q <= 1'b0;
            crc_err_q     <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            crc_q         <= crc_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            crc_err_q     <= crc_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign crc_err     = crc_err_q;
    assign err_count   = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_rx.sv
// ============================================================================
// Module      : tb_frame_rx
// Description : Directed self-checking bench for frame_rx (TIMEOUT=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_rx;

    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic       crc_err;
    logic       timeout_err;
    logic [7:0] err_count;

    int n_asserts = 0;
    int n_fail    = 0;

    frame_rx #(
        .KEY       (8'h37),
        .START     (8'h7E),
        .NODE_ADDR (8'h01),
        .TIMEOUT   (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .crc_err     (crc_err),
        .timeout_err (timeout_err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe followed by one idle cycle; returns on the negedge
    // just after the sampling posedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'h7E);
        send_byte(a);
        send_byte(d);
        send_byte(c);
    endtask

    // Expects a result pulse exactly one negedge later, gone the negedge after.
    task automatic expect_result(input string tag, input logic good,
                                 input logic [7:0] data, input logic [7:0] errs);
        check({tag, "_early"}, {6'd0, frame_valid, crc_err}, 8'h00);
        @(negedge clk);
        check({tag, "_valid"}, {7'd0, frame_valid}, {7'd0, good});
        check({tag, "_crcerr"}, {7'd0, crc_err}, {7'd0, !good});
        check({tag, "_data"}, frame_data, data);
        check({tag, "_errcnt"}, err_count, errs);
        @(negedge clk);
        check({tag, "_pulse_end"}, {6'd0, frame_valid, crc_err}, 8'h00);
    endtask

    initial begin
        rst      = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", frame_data, 8'h00);
        check("rst_valid", {7'd0, frame_valid}, 8'h00);
        check("rst_crcerr", {7'd0, crc_err}, 8'h00);
        check("rst_tmo", {7'd0, timeout_err}, 8'h00);
        check("rst_errcnt", err_count, 8'h00);
        rst = 1'b0;

        // AA ^ 37 = 9D
        send_frame(8'h01, 8'hAA, 8'h9D);
        expect_result("good", 1'b1, 8'hAA, 8'h00);

        // AD ^ 37 = 9A, broadcast address
        send_frame(8'hFF, 8'hAD, 8'h9A);
        expect_result("bcast", 1'b1, 8'hAD, 8'h00);

        send_frame(8'h01, 8'hAA, 8'h9C);
        expect_result("badcrc", 1'b0, 8'hAD, 8'h01);

        // Junk byte then wrong address: silently back to IDLE.
        send_byte(8'h55);
        send_byte(8'h7E);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'h9D);
        repeat (2) begin
            @(negedge clk);
            check("wrongaddr_nopulse", {6'd0, frame_valid, crc_err}, 8'h00);
        end
        check("wrongaddr_errcnt", err_count, 8'h01);
        check("wrongaddr_data", frame_data, 8'hAD);

        // AF ^ 37 = 98
        send_frame(8'h01, 8'hAF, 8'h98);
        expect_result("after_junk", 1'b1, 8'hAF, 8'h01);

        // START value as payload is ordinary content: 7E ^ 37 = 49
        send_frame(8'h01, 8'h7E, 8'h49);
        expect_result("start_payload", 1'b1, 8'h7E, 8'h01);

        // Reset mid-frame aborts without pulses.
        send_byte(8'h7E);
        send_byte(8'h01);
        send_byte(8'hAA);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h9D);
        repeat (3) begin
            @(negedge clk);
            check("midrst_nopulse", {6'd0, frame_valid, crc_err}, 8'h00);
        end
        check("midrst_data", frame_data, 8'h00);
        check("midrst_errcnt", err_count, 8'h00);

`ifdef FRAME_RX_TIMEOUT_EN
        send_byte(8'h7E);
        send_byte(8'h01);
        repeat (9) @(negedge clk);
        check("tmo_early", {7'd0, timeout_err}, 8'h00);
        @(negedge clk);
        check("tmo_pulse", {7'd0, timeout_err}, 8'h01);
        check("tmo_errcnt", err_count, 8'h01);
        check("tmo_nocrc", {7'd0, crc_err}, 8'h00);
        @(negedge clk);
        check("tmo_pulse_end", {7'd0, timeout_err}, 8'h00);
        // Back in IDLE: the next byte must be a START to frame anything.
        send_frame(8'h01, 8'hAA, 8'h9D);
        expect_result("after_tmo", 1'b1, 8'hAA, 8'h01);
`else
        // Without the timeout the receiver waits indefinitely mid-frame.
        send_byte(8'h7E);
        send_byte(8'h01);
        repeat (40) @(negedge clk);
        check("notmo_tmo", {7'd0, timeout_err}, 8'h00);
        check("notmo_errcnt", err_count, 8'h00);
        send_byte(8'hAA);
        send_byte(8'h9D);
        expect_result("notmo_resume", 1'b1, 8'hAA, 8'h00);
        // Keep the same starting count as the timeout build.
        send_frame(8'h01, 8'hAA, 8'h9C);
        expect_result("notmo_bad", 1'b0, 8'hAA, 8'h01);
`endif

        // Saturation: count starts at 1; 253 bad frames reach FE.
        for (int i = 0; i < 253; i++) begin
            send_frame(8'h01, 8'h00, 8'h00);
            @(negedge clk);
        end
        check("sat_fe", err_count, 8'hFE);
        for (int i = 0; i < 7; i++) begin
            send_frame(8'h01, 8'h00, 8'h00);
            @(negedge clk);
        end
        check("sat_ff", err_count, 8'hFF);
        send_frame(8'h01, 8'h11, 8'h00);
        expect_result("sat_hold", 1'b0, 8'hAA, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
